fbr_serial_tx: RTL
==================

// Module: fbr_serial_tx
// PURPOSE
//  Parallel-to-serial transmitter on the far side of the flag/bit register: accepts a WIDTH-bit word
//  through a load/ready handshake and drives it onto a single line as a framed serial stream.
//  Frame: start bit (0), WIDTH data bits LSB first, optional parity bit, stop bit (1); line idles high.
//  Sits between a register bank and an off-block serial link; the matching receiver samples tx.
// PARAMETERS
//  WIDTH         4  data bits per frame (>=1)
//  CLKS_PER_BIT  4  clk cycles each bit is held on tx (>=1)
// PORTS
//  clk    in   1      rising-edge clock; single clock domain
//  reset  in   1      synchronous, active-high reset
//  D      in   WIDTH  parallel word to send; sampled only on accepted load
//  load   in   1      request to send D
//  ready  out  1      1 = idle, load will be accepted this cycle
//  busy   out  1      1 = frame in progress (== ~ready)
//  tx     out  1      serial line, idle high
// BEHAVIOUR
//  - Reset (sampled at posedge clk): state IDLE, tx=1, ready=1, busy=0, shift reg and counters=0.
//  - Reset mid-frame aborts: tx=1 from the next cycle, no partial stop bit, D discarded.
//  - Accept: load && ready at a posedge; D latched into shift reg; all outputs registered.
//  - Latency: tx=0 (start) in the cycle after the accept edge; ready=0 same cycle.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    Each non-IDLE state lasts exactly CLKS_PER_BIT cycles (bit timer 0..CLKS_PER_BIT-1, wraps to 0).
//    DATA repeats WIDTH times; bit index 0..WIDTH-1, shift right on each bit-timer wrap.
//  - Frame length = (WIDTH+2[+1 parity]) * CLKS_PER_BIT cycles; ready returns 1 on the cycle after
//    the last stop-bit cycle.
//  - load while busy is ignored (not queued); D changes while busy have no effect.
//  - Back-to-back: load held high -> next start bit begins 1 cycle after ready rises (1 idle cycle, tx=1).
//  - load and reset in the same cycle: reset wins, no frame starts.
//  - Counter widths: $clog2(CLKS_PER_BIT) and $clog2(WIDTH), min 1 bit; CLKS_PER_BIT=1 is legal.
// CONFIGURATION
//  FBR_TX_PARITY_EN defined: PARITY state inserted after DATA, tx = ^D_latched (even parity:
//    total ones in data+parity even); frame is one bit longer.
//  Not defined: no PARITY state; DATA -> STOP directly; frame = (WIDTH+2)*CLKS_PER_BIT cycles.
// STRUCTURE
//  fbr_pkg: state enum typedef (IDLE, START, DATA, PARITY, STOP), TX_IDLE_LVL=1'b1,
//    START_LVL=1'b0, STOP_LVL=1'b1 constants.
//  Sub-module fbr_bit_timer: parameterised CLKS_PER_BIT counter with sync clear and one-cycle
//    'tick' on wrap; FSM advances only on tick.
// TESTING (WIDTH=4, CLKS_PER_BIT=4, 10 ns clk)
//  1 Reset held 2 cycles -> tx=1, ready=1, busy=0; release with load=0 -> outputs unchanged for 10 cycles.
//  2 D=4'b1010, load pulse 1 cycle -> tx: 0 x4, then 0,1,0,1 each x4, [parity 0 x4], 1 x4;
//    ready=0 for 24 (28) cycles then 1.
//  3 Mid-DATA, D=4'b1111 and load=1 -> ignored; frame bits still from 4'b1010; no second frame.
//  4 load held high, D=4'b1100 -> two identical frames separated by exactly 1 idle cycle at tx=1.
//  5 reset=1 during bit 2 of D=4'b0011 -> next cycle tx=1, ready=1; new load D=4'b0001 sends cleanly.
//  6 With FBR_TX_PARITY_EN, D=4'b0111 -> parity bit 1; D=4'b0110 -> parity bit 0.

Source files
------------

// File: rtl/fbr_serial_tx_pkg.sv
// fbr_pkg: FSM state type, line levels and a counter-width helper shared by the serial transmitter
package fbr_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic TX_IDLE_LVL = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL = 1'b1;
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fbr_serial_tx_bit_timer.sv
// fbr_bit_timer: counts 0..CLKS_PER_BIT-1 while not cleared, tick marks the last cycle of each bit
module fbr_bit_timer
    import fbr_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int TW = cw(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
    logic [TW-1:0] cnt;
    assign tick = !clr && cnt == LAST;
    always_ff @(posedge clk) begin
        if (reset || clr) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/fbr_serial_tx.sv
// fbr_serial_tx: framed LSB-first serial transmitter with load/ready handshake
// Define FBR_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fbr_serial_tx
    import fbr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    input  logic             load,
    output logic             ready,
    output logic             busy,
    output logic             tx
);
    localparam int IW = cw(WIDTH);
    state_t state;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] nsh;
    logic [IW-1:0] idx;
    logic tick;
    logic lastbit;
`ifdef FBR_TX_PARITY_EN
    logic par;
`endif
    fbr_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk(clk),
        .reset(reset),
        .clr(state == IDLE),
        .tick(tick)
    );
    assign nsh = sh >> 1;
    assign lastbit = idx == IW'(WIDTH - 1);
    // tx is registered, so each state drives the level of the bit that follows it on its final tick
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tx <= TX_IDLE_LVL;
            ready <= 1'b1;
            busy <= 1'b0;
            sh <= '0;
            idx <= '0;
`ifdef FBR_TX_PARITY_EN
            par <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (load) begin
                    state <= START;
                    tx <= START_LVL;
                    ready <= 1'b0;
                    busy <= 1'b1;
                    sh <= D;
                    idx <= '0;
`ifdef FBR_TX_PARITY_EN
                    par <= ^D;
`endif
                end
                START: if (tick) begin
                    state <= DATA;
                    tx <= sh[0];
                end
                DATA: if (tick) begin
                    if (lastbit) begin
`ifdef FBR_TX_PARITY_EN
                        state <= PARITY;
                        tx <= par;
`else
                        state <= STOP;
                        tx <= STOP_LVL;
`endif
                    end else begin
                        idx <= idx + 1'b1;
                        sh <= nsh;
                        tx <= nsh[0];
                    end
                end
`ifdef FBR_TX_PARITY_EN
                PARITY: if (tick) begin
                    state <= STOP;
                    tx <= STOP_LVL;
                end
`endif
                STOP: if (tick) begin
                    state <= IDLE;
                    tx <= TX_IDLE_LVL;
                    ready <= 1'b1;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
